// File: rtl/hazard_unit_ext.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_ext
// Purpose  : Decode-side hazard unit for the pipelined ARM core. Selects the
//            operand forwarding source per decode operand (MEM over WB),
//            inserts load-use bubbles, freezes the whole pipe while data
//            memory is busy, flags memory waits that run too long and counts
//            front-end stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit_ext #(
  parameter int ADDR_W      = 5,
  parameter int NUM_SRC     = 3,
  parameter int ZERO_REG    = 31,
  parameter int LU_CYCLES   = 1,    // 1..15 bubbles per load-use hazard
  parameter int MEM_TIMEOUT = 255,  // >= 1
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      ex_wr_en,
  input  logic                      ex_is_load,
  input  logic [ADDR_W-1:0]         ex_dst,
  input  logic                      mem_wr_en,
  input  logic [ADDR_W-1:0]         mem_dst,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  input  logic                      wb_wr_en,
  input  logic [ADDR_W-1:0]         wb_dst,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall_front,
  output logic                      bubble_ex,
  output logic                      freeze_all,
  output logic                      mem_timeout,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR  = ADDR_W'(ZERO_REG);
  localparam bit                LU_MULTI   = (LU_CYCLES > 1);
  localparam logic [3:0]        LU_RELOAD  = 4'(LU_CYCLES - 1);
  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          lu_cnt_q, lu_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0]  lu_match;
  logic                lu;
  logic                busy;

  // Per-operand forwarding select and load-use match against the EX destination
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [ADDR_W-1:0] src;
    logic              live;
    logic              mem_hit;
    logic              wb_hit;

    assign src     = id_src[i*ADDR_W +: ADDR_W];
    assign live    = id_src_used[i] && (src != ZERO_ADDR);
    assign mem_hit = live && mem_wr_en && (mem_dst == src);
    assign wb_hit  = live && wb_wr_en && (wb_dst == src);

    // MEM holds the younger result, so it shadows WB for the same register
    assign fwd_sel[2*i +: 2] = mem_hit ? 2'b01 : (wb_hit ? 2'b10 : 2'b00);
    assign lu_match[i]       = id_src_used[i] && (src == ex_dst);
  end

  assign lu   = id_valid && ex_wr_en && ex_is_load && (ex_dst != ZERO_ADDR) && (|lu_match);
  assign busy = mem_req && !mem_ready;

  // Stall control: outputs depend on the current state and the live inputs
  always_comb begin
    state_d     = state_q;
    lu_cnt_d    = lu_cnt_q;
    stall_front = 1'b0;
    bubble_ex   = 1'b0;
    freeze_all  = 1'b0;
    case (state_q)
      ST_LU_STALL: begin
        stall_front = 1'b1;
        if (busy) begin
          // Memory freeze pauses the bubble sequence without consuming it
          freeze_all = 1'b1;
        end else begin
          bubble_ex = 1'b1;
          lu_cnt_d  = lu_cnt_q - 4'd1;
          if (lu_cnt_q <= 4'd1) begin
            state_d  = ST_RUN;
            lu_cnt_d = 4'd0;
          end
        end
      end
      default: begin
        // RUN, and the completing cycle of MEM_WAIT, which behaves like RUN
        if (busy) begin
          freeze_all  = 1'b1;
          stall_front = 1'b1;
          state_d     = ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
          if (lu) begin
            stall_front = 1'b1;
            bubble_ex   = 1'b1;
            if (LU_MULTI) begin
              state_d  = ST_LU_STALL;
              lu_cnt_d = LU_RELOAD;
            end
          end
        end
      end
    endcase
  end

  // Watchdog: count busy MEM_WAIT cycles, latch the flag once the limit is hit
  always_comb begin
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    if ((state_q == ST_MEM_WAIT) && busy) begin
      wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : (wait_cnt_q + 1'b1);
    end
    if (wait_cnt_d == WAIT_LIMIT) begin
      mem_timeout_d = 1'b1;
    end
  end

  // Saturating count of front-end stall cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_front && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      lu_cnt_q      <= 4'd0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      lu_cnt_q      <= lu_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire
